aes_trace_sequencer: RTL and testbench

Synthesizable vector sequencer that sits directly in front of `AES_top` and replaces hand-timed testbench stimulus for power-trace acquisition. It holds up to DEPTH plaintexts and one key, launches encryptions back-to-back with a programmable idle gap, and optionally drives decoy data on the core input during gaps. It raises a scope trigger per encryption, returns each ciphertext with its index, and guards against a hung core with a timeout.

---
 rtl/aes_trace_sequencer_if.sv | 43 ++++
 rtl/aes_trace_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_aes_trace_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_trace_sequencer_if.sv
// Bundle of configuration, launch and AES-core signals around aes_trace_sequencer.
// master = host/stimulus side, slave = the sequencer.
interface aes_trace_sequencer_if #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              cfg_wr_en;
    logic [AW-1:0]     cfg_wr_addr;
    logic [DATA_W-1:0] cfg_wr_data;
    logic [DATA_W-1:0] cfg_key;
    logic [AW:0]       cfg_num;
    logic              cfg_loop;
    logic              start;
    logic              abort;
    logic              core_en;
    logic [DATA_W-1:0] core_data_in;
    logic [DATA_W-1:0] core_key_in;
    logic [DATA_W-1:0] core_data_out;
    logic              core_data_out_valid;
    logic              trig;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [AW-1:0]     res_index;
    logic              busy;
    logic              done;
    logic              err_timeout;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_key, cfg_num, cfg_loop,
               start, abort, core_data_out, core_data_out_valid,
        input  core_en, core_data_in, core_key_in, trig, res_valid, res_data,
               res_index, busy, done, err_timeout
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_key, cfg_num, cfg_loop,
               start, abort, core_data_out, core_data_out_valid,
        output core_en, core_data_in, core_key_in, trig, res_valid, res_data,
               res_index, busy, done, err_timeout
    );
endinterface

// File: rtl/aes_trace_sequencer.sv
// Plaintext-buffer sequencer that launches AES encryptions back-to-back for power-trace
// capture, with scope trigger, optional LFSR decoy data in the gaps, and a hung-core timeout.
module aes_trace_sequencer #(
    parameter int DATA_W     = 128,
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 15,
    parameter int TIMEOUT    = 64,
    parameter bit DECOY_EN   = 1'b1
) (
    input  logic                 AES_clk,
    input  logic                 AES_rst_n,
    aes_trace_sequencer_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int REP = DATA_W / 32;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    localparam logic [AW:0]     NUM_ZERO  = '0;
    localparam logic [AW:0]     NUM_ONE   = (AW+1)'(1);
    localparam logic [AW:0]     NUM_MAX   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   IDX_ZERO  = '0;
    localparam logic [AW-1:0]   IDX_ONE   = AW'(1);
    localparam logic [TW-1:0]   T_ZERO    = '0;
    localparam logic [TW-1:0]   T_ONE     = TW'(1);
    localparam logic [TW-1:0]   T_LAST    = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]   G_ZERO    = '0;
    localparam logic [GW-1:0]   G_ONE     = GW'(1);
    localparam logic [GW-1:0]   G_LOAD    = GW'(GAP_CYCLES);
    localparam logic [31:0]     LFSR_SEED = 32'hACE1_2468;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Fibonacci LFSR x^32+x^22+x^2+x+1, shifting towards the MSB.
    function automatic logic [31:0] f_lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    state_t            r_state, w_state;
    logic [DATA_W-1:0] r_buf [DEPTH];
    logic [AW-1:0]     r_idx, w_idx;
    logic [AW:0]       r_num, w_num;
    logic              r_loop, w_loop;
    logic [DATA_W-1:0] r_key, w_key;
    logic [DATA_W-1:0] r_data_in, w_data_in;
    logic              r_core_en, w_core_en;
    logic              r_trig, w_trig;
    logic              r_res_valid, w_res_valid;
    logic [DATA_W-1:0] r_res_data, w_res_data;
    logic [AW-1:0]     r_res_index, w_res_index;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_err, w_err;
    logic [TW-1:0]     r_tcnt, w_tcnt;
    logic [GW-1:0]     r_gcnt, w_gcnt;
    logic [31:0]       r_lfsr, w_lfsr;
    logic [31:0]       w_lfsr_step;
    logic [AW:0]       w_num_sat;
    logic              w_last;

    assign w_lfsr_step = f_lfsr_step(r_lfsr);
    assign w_num_sat   = (bus.cfg_num > NUM_MAX) ? NUM_MAX : bus.cfg_num;
    assign w_last      = ({1'b0, r_idx} == (r_num - NUM_ONE));

    // Plaintext buffer; writable only while idle.
    always_ff @(posedge AES_clk) begin
        if ((r_state == S_IDLE) && bus.cfg_wr_en && !bus.abort) begin
            r_buf[bus.cfg_wr_addr] <= bus.cfg_wr_data;
        end
    end

    // FSM state register.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_num       = r_num;
        w_loop      = r_loop;
        w_key       = r_key;
        w_data_in   = r_data_in;
        w_core_en   = r_core_en;
        w_trig      = r_trig;
        w_res_valid = 1'b0;
        w_res_data  = r_res_data;
        w_res_index = r_res_index;
        w_done      = 1'b0;
        w_err       = r_err;
        w_tcnt      = r_tcnt;
        w_gcnt      = r_gcnt;
        w_lfsr      = r_lfsr;
        if (bus.abort) begin
            w_state   = S_IDLE;
            w_core_en = 1'b0;
            w_trig    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && (bus.cfg_num != NUM_ZERO)) begin
                        w_state   = S_WAIT;
                        w_key     = bus.cfg_key;
                        w_num     = w_num_sat;
                        w_loop    = bus.cfg_loop;
                        w_idx     = IDX_ZERO;
                        w_err     = 1'b0;
                        w_tcnt    = T_ZERO;
                        w_data_in = r_buf[IDX_ZERO];
                        w_core_en = 1'b1;
                        w_trig    = 1'b1;
                    end else begin
                        w_state = S_IDLE;
                    end
                end
                S_WAIT: begin
                    // A valid on the final timeout cycle still counts as a result.
                    if (bus.core_data_out_valid) begin
                        w_res_valid = 1'b1;
                        w_res_data  = bus.core_data_out;
                        w_res_index = r_idx;
                        w_core_en   = 1'b0;
                        w_trig      = 1'b0;
                        if (w_last && !r_loop) begin
                            w_done  = 1'b1;
                            w_state = S_IDLE;
                        end else begin
                            w_idx   = w_last ? IDX_ZERO : (r_idx + IDX_ONE);
                            w_gcnt  = G_LOAD;
                            w_state = S_GAP;
                            if (DECOY_EN) begin
                                w_lfsr    = w_lfsr_step;
                                w_data_in = {REP{w_lfsr_step}};
                            end else begin
                                w_lfsr = r_lfsr;
                            end
                        end
                    end else if (r_tcnt == T_LAST) begin
                        w_core_en = 1'b0;
                        w_trig    = 1'b0;
                        w_err     = 1'b1;
                        w_state   = S_IDLE;
                    end else begin
                        w_tcnt = r_tcnt + T_ONE;
                    end
                end
                S_GAP: begin
                    if (r_gcnt == G_ZERO) begin
                        w_state   = S_WAIT;
                        w_data_in = r_buf[r_idx];
                        w_core_en = 1'b1;
                        w_trig    = 1'b1;
                        w_tcnt    = T_ZERO;
                    end else begin
                        w_gcnt = r_gcnt - G_ONE;
                        if (DECOY_EN) begin
                            w_lfsr    = w_lfsr_step;
                            w_data_in = {REP{w_lfsr_step}};
                        end else begin
                            w_lfsr = r_lfsr;
                        end
                    end
                end
                default: begin
                    w_state   = S_IDLE;
                    w_core_en = 1'b0;
                    w_trig    = 1'b0;
                end
            endcase
        end
        w_busy = (w_state != S_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_idx       <= '0;
            r_num       <= '0;
            r_loop      <= 1'b0;
            r_key       <= '0;
            r_data_in   <= '0;
            r_core_en   <= 1'b0;
            r_trig      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_index <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_tcnt      <= '0;
            r_gcnt      <= '0;
            r_lfsr      <= LFSR_SEED;
        end else begin
            r_idx       <= w_idx;
            r_num       <= w_num;
            r_loop      <= w_loop;
            r_key       <= w_key;
            r_data_in   <= w_data_in;
            r_core_en   <= w_core_en;
            r_trig      <= w_trig;
            r_res_valid <= w_res_valid;
            r_res_data  <= w_res_data;
            r_res_index <= w_res_index;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
            r_tcnt      <= w_tcnt;
            r_gcnt      <= w_gcnt;
            r_lfsr      <= w_lfsr;
        end
    end

    assign bus.core_en      = r_core_en;
    assign bus.core_data_in = r_data_in;
    assign bus.core_key_in  = r_key;
    assign bus.trig         = r_trig;
    assign bus.res_valid    = r_res_valid;
    assign bus.res_data     = r_res_data;
    assign bus.res_index    = r_res_index;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err_timeout  = r_err;
endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Directed bench for aes_trace_sequencer: a decoy-on DUT and a decoy-off DUT run in
// lockstep, each fed by a behavioural AES core (valid 10 cycles after launch, out = data^key).
module tb_aes_trace_sequencer;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    bit   mute = 1'b0;
    int   m0_cnt, m1_cnt;

    logic [127:0] pt [3];
    logic [127:0] key  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    logic [127:0] key2 = 128'h01234567_89abcdef_fedcba98_76543210;

    logic [127:0] rq_data [$];
    logic [3:0]   rq_idx  [$];
    logic         rq_done [$];
    int           gap_q   [$];
    int           n_done = 0;
    int           n_trig = 0;
    int           low_run = 0;

    aes_trace_sequencer_if #(.DATA_W(128), .DEPTH(16)) bus0 ();
    aes_trace_sequencer_if #(.DATA_W(128), .DEPTH(16)) bus1 ();

    aes_trace_sequencer #(.DATA_W(128), .DEPTH(16), .GAP_CYCLES(15), .TIMEOUT(64), .DECOY_EN(1'b1))
        dut0 (.AES_clk(clk), .AES_rst_n(rst_n), .bus(bus0));
    aes_trace_sequencer #(.DATA_W(128), .DEPTH(16), .GAP_CYCLES(15), .TIMEOUT(64), .DECOY_EN(1'b0))
        dut1 (.AES_clk(clk), .AES_rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural AES cores.
    always @(posedge clk) begin
        if (!rst_n || !bus0.core_en) begin
            m0_cnt <= 0;
            bus0.core_data_out_valid <= 1'b0;
        end else begin
            m0_cnt <= m0_cnt + 1;
            bus0.core_data_out_valid <= !mute && (m0_cnt == 8);
        end
        bus0.core_data_out <= bus0.core_data_in ^ bus0.core_key_in;
    end
    always @(posedge clk) begin
        if (!rst_n || !bus1.core_en) begin
            m1_cnt <= 0;
            bus1.core_data_out_valid <= 1'b0;
        end else begin
            m1_cnt <= m1_cnt + 1;
            bus1.core_data_out_valid <= !mute && (m1_cnt == 8);
        end
        bus1.core_data_out <= bus1.core_data_in ^ bus1.core_key_in;
    end

    // Result / trigger / launch-gap monitor on dut0.
    always @(negedge clk) begin
        if (bus0.res_valid) begin
            rq_data.push_back(bus0.res_data);
            rq_idx.push_back(bus0.res_index);
            rq_done.push_back(bus0.done);
        end
        if (bus0.done) n_done++;
        if (bus0.trig) n_trig++;
        if (!bus0.busy) low_run = 0;
        else if (!bus0.core_en) low_run++;
        else begin
            if (low_run > 0) gap_q.push_back(low_run);
            low_run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic write_buf(input logic [3:0] addr, input logic [127:0] data);
        bus0.cfg_wr_en = 1'b1; bus0.cfg_wr_addr = addr; bus0.cfg_wr_data = data;
        bus1.cfg_wr_en = 1'b1; bus1.cfg_wr_addr = addr; bus1.cfg_wr_data = data;
        tick();
        bus0.cfg_wr_en = 1'b0;
        bus1.cfg_wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] num, input logic loop, input logic [127:0] k);
        bus0.cfg_num = num; bus0.cfg_loop = loop; bus0.cfg_key = k; bus0.start = 1'b1;
        bus1.cfg_num = num; bus1.cfg_loop = loop; bus1.cfg_key = k; bus1.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic set_abort(input logic a);
        bus0.abort = a;
        bus1.abort = a;
    endtask

    // sel: 0 res_valid, 1 done, 2 core_en, 3 core_data_out_valid
    task automatic wait_for(input int sel, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if ((sel == 0 && bus0.res_valid) || (sel == 1 && bus0.done) ||
                (sel == 2 && bus0.core_en) || (sel == 3 && bus0.core_data_out_valid)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus0.core_en, bus0.trig, bus0.res_valid, bus0.busy, bus0.done, bus0.err_timeout} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000",
                {bus0.core_en, bus0.trig, bus0.res_valid, bus0.busy, bus0.done, bus0.err_timeout});
        end
        checks++;
        if ({bus0.core_data_in, bus0.core_key_in, bus0.res_data} !== 384'b0 || bus0.res_index !== 4'd0) begin
            errors++; $display("FAIL reset_data: data_in %h key_in %h res %h idx %0d want all 0",
                bus0.core_data_in, bus0.core_key_in, bus0.res_data, bus0.res_index);
        end
    endtask

    task automatic test_single();
        bit ok;
        int tb0;
        write_buf(4'd0, 128'h00000061_00000000_00000000_00000000);
        tb0 = n_trig;
        pulse_start(5'd1, 1'b0, key);
        checks++;
        if (bus0.core_en !== 1'b1 || bus0.trig !== 1'b1 || bus0.busy !== 1'b1) begin
            errors++; $display("FAIL single_launch: en %b trig %b busy %b want 1 1 1",
                bus0.core_en, bus0.trig, bus0.busy);
        end
        checks++;
        if (bus0.core_data_in !== 128'h00000061_00000000_00000000_00000000 || bus0.core_key_in !== key) begin
            errors++; $display("FAIL single_inputs: data %h key %h", bus0.core_data_in, bus0.core_key_in);
        end
        wait_for(0, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_wait: no res_valid within 40 cycles"); end
        checks++;
        if (bus0.res_data !== 128'haa2bdb21_bff6a5e8_caa9ba3e_bc1e2acc) begin
            errors++; $display("FAIL single_data: got %h want aa2bdb21bff6a5e8caa9ba3ebc1e2acc", bus0.res_data);
        end
        checks++;
        if (bus0.res_index !== 4'd0 || bus0.done !== 1'b1) begin
            errors++; $display("FAIL single_idx_done: idx %0d done %b want 0 1", bus0.res_index, bus0.done);
        end
        tick();
        checks++;
        if (n_trig - tb0 != 10) begin
            errors++; $display("FAIL single_trig_len: got %0d want 10", n_trig - tb0);
        end
        checks++;
        if (bus0.busy !== 1'b0 || bus0.res_valid !== 1'b0 || bus0.core_en !== 1'b0) begin
            errors++; $display("FAIL single_end: busy %b res_valid %b en %b want 0 0 0",
                bus0.busy, bus0.res_valid, bus0.core_en);
        end
    endtask

    task automatic test_decoy();
        bit ok;
        write_buf(4'd0, pt[0]);
        write_buf(4'd1, pt[1]);
        write_buf(4'd2, pt[2]);
        pulse_start(5'd2, 1'b0, key);
        wait_for(0, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL decoy_wait: no res_valid within 40 cycles"); end
        checks++;
        if (bus0.core_data_in !== {4{32'h59C248D0}} || bus0.core_en !== 1'b0) begin
            errors++; $display("FAIL decoy_step1: got %h en %b want 4x59c248d0 en 0",
                bus0.core_data_in, bus0.core_en);
        end
        checks++;
        if (bus1.core_data_in !== pt[0]) begin
            errors++; $display("FAIL decoy_off_hold1: got %h want %h", bus1.core_data_in, pt[0]);
        end
        tick();
        checks++;
        if (bus0.core_data_in !== {4{32'hB38491A0}}) begin
            errors++; $display("FAIL decoy_step2: got %h want 4xb38491a0", bus0.core_data_in);
        end
        checks++;
        if (bus1.core_data_in !== pt[0]) begin
            errors++; $display("FAIL decoy_off_hold2: got %h want %h", bus1.core_data_in, pt[0]);
        end
        wait_for(1, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL decoy_done: no done within 60 cycles"); end
        tick();
    endtask

    task automatic test_three_vector();
        bit ok;
        int rb, gb, db;
        rb = rq_data.size(); gb = gap_q.size(); db = n_done;
        pulse_start(5'd3, 1'b0, key);
        wait_for(1, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL three_wait: no done within 200 cycles"); end
        tick();
        checks++;
        if (rq_data.size() - rb != 3 || n_done - db != 1) begin
            errors++; $display("FAIL three_counts: results %0d done %0d want 3 1",
                rq_data.size() - rb, n_done - db);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rq_data[rb+i] !== (pt[i] ^ key) || rq_idx[rb+i] !== i[3:0] || rq_done[rb+i] !== (i == 2)) begin
                    errors++; $display("FAIL three_result%0d: data %h idx %0d done %b want %h %0d %b",
                        i, rq_data[rb+i], rq_idx[rb+i], rq_done[rb+i], pt[i] ^ key, i, i == 2);
                end
            end
        end
        checks++;
        if (gap_q.size() - gb != 2) begin
            errors++; $display("FAIL three_gap_count: got %0d gaps want 2", gap_q.size() - gb);
        end else begin
            checks++;
            if (gap_q[gb] != 16 || gap_q[gb+1] != 16) begin
                errors++; $display("FAIL three_gap_len: got %0d %0d want 16 16", gap_q[gb], gap_q[gb+1]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int rb, db;
        mute = 1'b1;
        rb = rq_data.size(); db = n_done;
        pulse_start(5'd1, 1'b0, key);
        repeat (63) tick();
        checks++;
        if (bus0.err_timeout !== 1'b0 || bus0.busy !== 1'b1 || bus0.core_en !== 1'b1) begin
            errors++; $display("FAIL timeout_early: err %b busy %b en %b want 0 1 1",
                bus0.err_timeout, bus0.busy, bus0.core_en);
        end
        tick();
        checks++;
        if (bus0.err_timeout !== 1'b1 || bus0.busy !== 1'b0 || bus0.core_en !== 1'b0) begin
            errors++; $display("FAIL timeout_hit: err %b busy %b en %b want 1 0 0",
                bus0.err_timeout, bus0.busy, bus0.core_en);
        end
        checks++;
        if (n_done != db || rq_data.size() != rb) begin
            errors++; $display("FAIL timeout_no_result: done %0d results %0d want 0 0",
                n_done - db, rq_data.size() - rb);
        end
        mute = 1'b0;
        tick();
        pulse_start(5'd1, 1'b0, key);
        checks++;
        if (bus0.err_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: err %b want 0", bus0.err_timeout);
        end
        wait_for(1, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_rerun: no done within 40 cycles"); end
        tick();
    endtask

    task automatic test_abort_and_busy_start();
        bit ok;
        int rb;
        rb = rq_data.size();
        pulse_start(5'd2, 1'b1, key);
        wait_for(0, 40, ok);
        checks++;
        if (!ok || bus0.res_index !== 4'd0) begin
            errors++; $display("FAIL abort_first: seen %b idx %0d want 1 0", ok, bus0.res_index);
        end
        tick();
        pulse_start(5'd1, 1'b0, key2);
        checks++;
        if (bus0.busy !== 1'b1 || bus0.core_key_in !== key) begin
            errors++; $display("FAIL busy_start_ignored: busy %b key %h want 1 %h", bus0.busy, bus0.core_key_in, key);
        end
        wait_for(0, 40, ok);
        checks++;
        if (!ok || bus0.res_index !== 4'd1 || bus0.done !== 1'b0) begin
            errors++; $display("FAIL abort_second: seen %b idx %0d done %b want 1 1 0", ok, bus0.res_index, bus0.done);
        end
        wait_for(2, 40, ok);
        checks++;
        if (!ok || bus0.core_data_in !== pt[0]) begin
            errors++; $display("FAIL abort_wrap: seen %b data %h want %h", ok, bus0.core_data_in, pt[0]);
        end
        wait_for(3, 40, ok);
        set_abort(1'b1);
        tick();
        set_abort(1'b0);
        checks++;
        if (!ok || bus0.res_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.core_en !== 1'b0 || bus0.trig !== 1'b0) begin
            errors++; $display("FAIL abort_state: seen %b res_valid %b busy %b en %b trig %b want 1 0 0 0 0",
                ok, bus0.res_valid, bus0.busy, bus0.core_en, bus0.trig);
        end
        checks++;
        if (bus0.core_key_in !== key || bus0.core_data_in !== pt[0] || bus0.done !== 1'b0 || bus0.err_timeout !== 1'b0) begin
            errors++; $display("FAIL abort_hold: key %h data %h done %b err %b",
                bus0.core_key_in, bus0.core_data_in, bus0.done, bus0.err_timeout);
        end
        repeat (3) tick();
        checks++;
        if (rq_data.size() - rb != 2 || bus0.busy !== 1'b0) begin
            errors++; $display("FAIL abort_discard: results %0d busy %b want 2 0", rq_data.size() - rb, bus0.busy);
        end
    endtask

    task automatic test_async_reset();
        pulse_start(5'd1, 1'b0, key);
        repeat (3) tick();
        checks++;
        if (bus0.busy !== 1'b1 || bus0.core_en !== 1'b1) begin
            errors++; $display("FAIL areset_pre: busy %b en %b want 1 1", bus0.busy, bus0.core_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus0.core_en, bus0.trig, bus0.busy, bus0.res_valid, bus0.done, bus0.err_timeout} !== 6'b0 ||
            bus0.core_data_in !== 128'b0 || bus0.core_key_in !== 128'b0) begin
            errors++; $display("FAIL areset_clear: en %b trig %b busy %b data %h key %h want all 0",
                bus0.core_en, bus0.trig, bus0.busy, bus0.core_data_in, bus0.core_key_in);
        end
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start(5'd0, 1'b0, key);
        tick();
        checks++;
        if (bus0.busy !== 1'b0 || bus0.core_en !== 1'b0) begin
            errors++; $display("FAIL num0_start: busy %b en %b want 0 0", bus0.busy, bus0.core_en);
        end
    endtask

    initial begin
        pt[0] = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
        pt[1] = 128'hd7b26248_e8351227_5573a1e5_e8f263b3;
        pt[2] = 128'hf301a68a_9e9ffa50_844581d9_e290d818;
        rst_n = 1'b0;
        bus0.cfg_wr_en = 1'b0; bus0.cfg_wr_addr = 4'd0; bus0.cfg_wr_data = 128'b0;
        bus0.cfg_key = 128'b0; bus0.cfg_num = 5'd0; bus0.cfg_loop = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0;
        bus1.cfg_wr_en = 1'b0; bus1.cfg_wr_addr = 4'd0; bus1.cfg_wr_data = 128'b0;
        bus1.cfg_key = 128'b0; bus1.cfg_num = 5'd0; bus1.cfg_loop = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_single();
        test_decoy();
        test_three_vector();
        test_timeout();
        test_abort_and_busy_start();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
